// File: rtl/ram_sdp_be_if.sv
// ram_sdp_be_if: write/read request bus of the simple dual-port byte-enable RAM
interface ram_sdp_be_if #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = 7
);
  localparam int NB = DATA_WIDTH / BYTE_WIDTH;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [NB-1:0]         wr_be;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  rd_err;
  logic                  init_done;
  modport master (
    output wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
    input  rd_data, rd_valid, rd_err, init_done
  );
  modport slave (
    input  wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
    output rd_data, rd_valid, rd_err, init_done
  );
endinterface

// File: rtl/ram_sdp_be.sv
// ram_sdp_be: simple dual-port byte-enable RAM, RD_LATENCY 1/2, RDW old/new; post-reset zero clear under RAM_SDP_BE_CLEAR_EN
module ram_sdp_be #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = 7,
  parameter int MEM_DEPTH  = 128,
  parameter int RD_LATENCY = 1,
  parameter int RDW_MODE   = 0
) (
  input logic        clk,
  input logic        rst_n,
  ram_sdp_be_if.slave bus
);
  localparam int NB = DATA_WIDTH / BYTE_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(MEM_DEPTH);
  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_lat
    $error("ram_sdp_be: RD_LATENCY must be 1 or 2");
  end
  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
    $error("ram_sdp_be: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if (MEM_DEPTH < 1 || MEM_DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
    $error("ram_sdp_be: MEM_DEPTH out of range");
  end
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] be_mask, rd_old, rd_word, d1;
  logic                  init_done, clr, we, re, rd_in, v1, e1;
  logic [ADDR_WIDTH-1:0] clr_addr;
`ifdef RAM_SDP_BE_CLEAR_EN
  typedef enum logic {CLEAR, READY} state_t;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(MEM_DEPTH - 1);
  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] clr_nxt;
  // Clear FSM state and sweep pointer; reset always restarts the sweep at word 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= CLEAR;
      clr_addr <= '0;
    end else begin
      state    <= state_nxt;
      clr_addr <= clr_nxt;
    end
  end
  // Step one word per cycle through the array, then park in READY
  always_comb begin
    state_nxt = (state == CLEAR && clr_addr == LAST) ? READY : state;
    clr_nxt   = (state == CLEAR) ? clr_addr + 1'b1 : clr_addr;
  end
  assign clr       = state == CLEAR;
  assign init_done = state == READY;
`else
  assign clr       = 1'b0;
  assign init_done = 1'b1;
  assign clr_addr  = '0;
`endif
  assign bus.init_done = init_done;
  assign we    = bus.wr_en && init_done && ({1'b0, bus.wr_addr} < DEPTH);
  assign re    = bus.rd_en && init_done;
  assign rd_in = {1'b0, bus.rd_addr} < DEPTH;
  // Expand lane enables to a bit mask for same-address forwarding
  always_comb begin
    be_mask = '0;
    for (int i = 0; i < NB; i++) be_mask[i*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{bus.wr_be[i]}};
  end
  assign rd_old  = mem[bus.rd_addr];
  assign rd_word = (RDW_MODE == 1 && we && bus.wr_addr == bus.rd_addr) ?
                   (rd_old & ~be_mask) | (bus.wr_data & be_mask) : rd_old;
  // Array write port: clear sweep has priority, user writes only touch enabled lanes
  always_ff @(posedge clk) begin
    if (clr) mem[clr_addr] <= '0;
    else if (we)
      for (int i = 0; i < NB; i++)
        if (bus.wr_be[i]) mem[bus.wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= bus.wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
  end
  // First read stage: data holds between reads, out-of-range reads return zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1 <= '0;
      v1 <= 1'b0;
      e1 <= 1'b0;
    end else begin
      v1 <= re;
      e1 <= re && !rd_in;
      if (re) d1 <= rd_in ? rd_word : '0;
    end
  end
  if (RD_LATENCY == 1) begin : g_lat1
    assign bus.rd_data  = d1;
    assign bus.rd_valid = v1;
    assign bus.rd_err   = e1;
  end else begin : g_lat2
    logic [DATA_WIDTH-1:0] d2;
    logic                  v2, e2;
    // Second read stage: forwards completed reads one cycle later
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        d2 <= '0;
        v2 <= 1'b0;
        e2 <= 1'b0;
      end else begin
        v2 <= v1;
        e2 <= e1;
        if (v1) d2 <= d1;
      end
    end
    assign bus.rd_data  = d2;
    assign bus.rd_valid = v2;
    assign bus.rd_err   = e2;
  end
endmodule

// File: tb/tb_ram_sdp_be.sv
// tb_ram_sdp_be: two RAM configurations driven in lockstep against a word-array reference model
module tb_ram_sdp_be;
`ifdef RAM_SDP_BE_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif
  localparam int DEP [2] = '{128, 100};
  localparam int LAT [2] = '{1, 2};
  localparam int RDW [2] = '{0, 1};
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  logic        wr_en = 1'b0, rd_en = 1'b0;
  logic [6:0]  wr_addr = '0, rd_addr = '0;
  logic [3:0]  wr_be = '0;
  logic [31:0] wr_data = '0;
  ram_sdp_be_if #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(7)) ifa ();
  ram_sdp_be_if #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(7)) ifb ();
  assign ifa.wr_en = wr_en;   assign ifb.wr_en = wr_en;
  assign ifa.wr_addr = wr_addr; assign ifb.wr_addr = wr_addr;
  assign ifa.wr_be = wr_be;   assign ifb.wr_be = wr_be;
  assign ifa.wr_data = wr_data; assign ifb.wr_data = wr_data;
  assign ifa.rd_en = rd_en;   assign ifb.rd_en = rd_en;
  assign ifa.rd_addr = rd_addr; assign ifb.rd_addr = rd_addr;
  ram_sdp_be dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  ram_sdp_be #(.MEM_DEPTH(100), .RD_LATENCY(2), .RDW_MODE(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));
  logic [31:0] o_d [2];
  logic        o_v [2], o_e [2], o_i [2];
  assign o_d[0] = ifa.rd_data;  assign o_d[1] = ifb.rd_data;
  assign o_v[0] = ifa.rd_valid; assign o_v[1] = ifb.rd_valid;
  assign o_e[0] = ifa.rd_err;   assign o_e[1] = ifb.rd_err;
  assign o_i[0] = ifa.init_done; assign o_i[1] = ifb.init_done;
  logic [31:0] m [2][128];
  int          cnt [2];
  int          cyc = 0;
  bit          ev [2][4];
  logic [31:0] ed [2][4];
  bit          ee [2][4];
  logic [31:0] last [2];
  int          n_cmp = 0, n_bad = 0;
  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] be);
    for (int i = 0; i < 4; i++) if (be[i]) old[8*i +: 8] = nw[8*i +: 8];
    return old;
  endfunction
  // reference model: per-edge effect of the requests on each configuration
  always @(posedge clk) begin
    bit          rdy;
    logic [31:0] w;
    int          s;
    if (!rst_n) cnt = '{0, 0};
    else begin
      cyc++;
      for (int j = 0; j < 2; j++) begin
        rdy = !CLR || cnt[j] >= DEP[j];
        if (rdy && rd_en) begin
          w = (int'(rd_addr) < DEP[j]) ? m[j][rd_addr] : 32'h0;
          if (RDW[j] == 1 && wr_en && wr_addr == rd_addr && int'(rd_addr) < DEP[j]) w = merge(w, wr_data, wr_be);
          s = (cyc + LAT[j] - 1) % 4;
          ev[j][s] = 1'b1;
          ed[j][s] = w;
          ee[j][s] = int'(rd_addr) >= DEP[j];
        end
        if (rdy && wr_en && int'(wr_addr) < DEP[j]) m[j][wr_addr] = merge(m[j][wr_addr], wr_data, wr_be);
        if (!rdy) begin
          cnt[j]++;
          if (cnt[j] == DEP[j]) for (int a = 0; a < 128; a++) m[j][a] = 32'h0;
        end
      end
    end
  end
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask
  task automatic verify();
    int s;
    s = cyc % 4;
    for (int j = 0; j < 2; j++) begin
      if (ev[j][s]) last[j] = ed[j][s];
      check($sformatf("dut%0d_valid", j), 32'(o_v[j]), 32'(ev[j][s]));
      check($sformatf("dut%0d_data", j), o_d[j], last[j]);
      check($sformatf("dut%0d_err", j), 32'(o_e[j]), ev[j][s] ? 32'(ee[j][s]) : 32'h0);
      check($sformatf("dut%0d_init", j), 32'(o_i[j]), 32'(!CLR || cnt[j] >= DEP[j]));
      ev[j][s] = 1'b0;
    end
  endtask
  task automatic step(bit we, logic [6:0] wa, logic [3:0] be, logic [31:0] wd, bit re, logic [6:0] ra);
    wr_en = we; wr_addr = wa; wr_be = be; wr_data = wd; rd_en = re; rd_addr = ra;
    @(negedge clk);
    verify();
  endtask
  task automatic idle(int n);
    repeat (n) step(1'b0, '0, '0, '0, 1'b0, '0);
  endtask
  task automatic do_reset(int hold);
    rst_n = 1'b0;
    wr_en = 1'b0; rd_en = 1'b0;
    #1;
    for (int j = 0; j < 2; j++) begin
      check($sformatf("rst%0d_data", j), o_d[j], 32'h0);
      check($sformatf("rst%0d_valid", j), 32'(o_v[j]), 32'h0);
      check($sformatf("rst%0d_err", j), 32'(o_e[j]), 32'h0);
      check($sformatf("rst%0d_init", j), 32'(o_i[j]), 32'(!CLR));
      for (int s = 0; s < 4; s++) ev[j][s] = 1'b0;
      last[j] = 32'h0;
      cnt[j] = 0;
    end
    idle(hold);
    rst_n = 1'b1;
  endtask
  task automatic wait_ready();
    for (int k = 0; k < 400 && !(o_i[0] && o_i[1]); k++) idle(1);
    check("init_done", {30'h0, o_i[0], o_i[1]}, 32'h3);
  endtask
  function automatic logic [6:0] rnd_addr();
    return ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 3)) : 7'($urandom_range(0, 127));
  endfunction
  task automatic random_run(int n);
    repeat (n) step(1'($urandom), rnd_addr(), 4'($urandom), $urandom, 1'($urandom), rnd_addr());
  endtask
  initial begin
    last = '{32'h0, 32'h0};
    #2;
    do_reset(3);
    wait_ready();
    for (int a = 0; a < 128; a++) step(1'b1, 7'(a), 4'hF, $urandom, 1'b0, '0);
    step(1'b1, 7'd5, 4'hF, 32'hAABBCCDD, 1'b0, '0);
    step(1'b1, 7'd5, 4'b0101, 32'h11223344, 1'b0, '0);
    step(1'b0, '0, '0, '0, 1'b1, 7'd5);
    check("lanes_a", o_d[0], 32'hAA22CC44);
    idle(1);
    check("lanes_b", o_d[1], 32'hAA22CC44);
    step(1'b1, 7'd9, 4'hF, 32'h0, 1'b0, '0);
    step(1'b1, 7'd9, 4'hF, 32'hDEADBEEF, 1'b1, 7'd9);
    check("rdw_old_a", o_d[0], 32'h0);
    step(1'b0, '0, '0, '0, 1'b1, 7'd9);
    check("rdw_new_b", o_d[1], 32'hDEADBEEF);
    check("rdw_after_a", o_d[0], 32'hDEADBEEF);
    idle(1);
    check("rdw_after_b", o_d[1], 32'hDEADBEEF);
    step(1'b1, 7'd20, 4'hF, 32'h77, 1'b0, '0);
    step(1'b1, 7'd120, 4'hF, 32'h5, 1'b0, '0);
    step(1'b0, '0, '0, '0, 1'b1, 7'd120);
    idle(1);
    check("oob_err_b", {31'h0, o_e[1]}, 32'h1);
    check("oob_data_b", o_d[1], 32'h0);
    step(1'b0, '0, '0, '0, 1'b1, 7'd20);
    idle(1);
    check("alias_b", o_d[1], 32'h77);
    for (int a = 0; a < 4; a++) step(1'b0, '0, '0, '0, 1'b1, 7'(a));
    idle(2);
    random_run(3000);
    repeat (3) step(1'b0, '0, '0, '0, 1'b1, rnd_addr());
    do_reset(2);
    if (CLR) begin
      repeat (50) step(1'b1, rnd_addr(), 4'hF, $urandom, 1'b1, rnd_addr());
      do_reset(2);
    end
    wait_ready();
    for (int a = 0; a < 128; a++) step(1'b0, '0, '0, '0, 1'b1, 7'(a));
    idle(2);
    random_run(1000);
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
